i2s_frame_sched: RTL

//  Master timing and sample scheduler for the stereo i2s transmit path. Generates bclk (64x fs),

---
 rtl/i2s_frame_sched.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/i2s_frame_sched.sv
// Stereo i2s master timing and sample scheduler: generates bclk/lrclk/sampstart and
// fetches one L/R pair per frame from the synth engine, with underflow handling.
module i2s_frame_sched #(
    parameter int unsigned BCLK_HALF  = 4,
    parameter int unsigned REQ_BIT    = 8,
    parameter int unsigned MUTE_UFLOW = 0
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        enable_i,
    output logic        smp_req_o,
    input  logic        smp_valid_i,
    input  logic [23:0] smp_l_i,
    input  logic [23:0] smp_r_i,
    output logic        bclk_o,
    output logic        lrclk_o,
    output logic        sampstart_o,
    output logic [23:0] audio_l_o,
    output logic [23:0] audio_r_o,
    output logic        uflow_o,
    output logic [7:0]  uflow_cnt_o
);

    localparam int unsigned SW  = 24;
    localparam int unsigned HW  = $clog2(BCLK_HALF);
    localparam int unsigned BW  = 6;
    localparam int unsigned UCW = 8;

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state_q, state_d;
    logic [HW-1:0]   half_q, half_d;
    logic [BW-1:0]   bit_q, bit_d;
    logic            bclk_q, bclk_d;
    logic            lrclk_q, lrclk_d;
    logic            ss_q, ss_d;
    logic            req_q, req_d;
    logic [SW-1:0]   pend_l_q, pend_l_d, pend_r_q, pend_r_d;
    logic            fresh_q, fresh_d;
    logic [SW-1:0]   aud_l_q, aud_l_d, aud_r_q, aud_r_d;
    logic            uflow_q, uflow_d;
    logic [UCW-1:0]  ucnt_q, ucnt_d;

    logic            half_tc;
    logic            fall;
    logic [BW-1:0]   bit_nxt;

    assign half_tc = (half_q == HW'(BCLK_HALF - 1));
    assign fall    = half_tc && bclk_q;
    assign bit_nxt = bit_q + BW'(1);

    // Next-state and registered-output logic
    always_comb begin
        state_d  = state_q;
        half_d   = half_q;
        bit_d    = bit_q;
        bclk_d   = bclk_q;
        lrclk_d  = lrclk_q;
        ss_d     = 1'b0;
        req_d    = req_q;
        pend_l_d = pend_l_q;
        pend_r_d = pend_r_q;
        fresh_d  = fresh_q;
        aud_l_d  = aud_l_q;
        aud_r_d  = aud_r_q;
        uflow_d  = 1'b0;
        ucnt_d   = ucnt_q;

        case (state_q)
            IDLE: begin
                half_d   = '0;
                bit_d    = '0;
                bclk_d   = 1'b0;
                lrclk_d  = 1'b0;
                req_d    = 1'b0;
                pend_l_d = '0;
                pend_r_d = '0;
                fresh_d  = 1'b0;
                if (enable_i) begin
                    state_d = RUN;
                    ss_d    = 1'b1;
                    aud_l_d = '0;
                    aud_r_d = '0;
                end
            end
            RUN: begin
                if (!enable_i) begin
                    state_d  = IDLE;
                    half_d   = '0;
                    bit_d    = '0;
                    bclk_d   = 1'b0;
                    lrclk_d  = 1'b0;
                    req_d    = 1'b0;
                    pend_l_d = '0;
                    pend_r_d = '0;
                    fresh_d  = 1'b0;
                end else begin
                    half_d = half_tc ? '0 : half_q + HW'(1);
                    if (half_tc) begin
                        bclk_d = ~bclk_q;
                    end
                    if (fall) begin
                        bit_d   = bit_nxt;
                        lrclk_d = bit_nxt[BW-1];
                    end
                    // Frame wrap: withdraw any open request, present the pair or underflow
                    if (fall && (bit_q == BW'(63))) begin
                        ss_d  = 1'b1;
                        req_d = 1'b0;
                        if (fresh_q) begin
                            aud_l_d = pend_l_q;
                            aud_r_d = pend_r_q;
                            fresh_d = 1'b0;
                        end else begin
                            uflow_d = 1'b1;
                            if (ucnt_q != {UCW{1'b1}}) begin
                                ucnt_d = ucnt_q + UCW'(1);
                            end
                            if (MUTE_UFLOW != 0) begin
                                aud_l_d = '0;
                                aud_r_d = '0;
                            end
                        end
                    end else if (req_q && smp_valid_i) begin
                        pend_l_d = smp_l_i;
                        pend_r_d = smp_r_i;
                        fresh_d  = 1'b1;
                        req_d    = 1'b0;
                    end else if (fall && (bit_nxt == BW'(REQ_BIT))) begin
                        req_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q  <= IDLE;
            half_q   <= '0;
            bit_q    <= '0;
            bclk_q   <= 1'b0;
            lrclk_q  <= 1'b0;
            ss_q     <= 1'b0;
            req_q    <= 1'b0;
            pend_l_q <= '0;
            pend_r_q <= '0;
            fresh_q  <= 1'b0;
            aud_l_q  <= '0;
            aud_r_q  <= '0;
            uflow_q  <= 1'b0;
            ucnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            half_q   <= half_d;
            bit_q    <= bit_d;
            bclk_q   <= bclk_d;
            lrclk_q  <= lrclk_d;
            ss_q     <= ss_d;
            req_q    <= req_d;
            pend_l_q <= pend_l_d;
            pend_r_q <= pend_r_d;
            fresh_q  <= fresh_d;
            aud_l_q  <= aud_l_d;
            aud_r_q  <= aud_r_d;
            uflow_q  <= uflow_d;
            ucnt_q   <= ucnt_d;
        end
    end

    assign smp_req_o   = req_q;
    assign bclk_o      = bclk_q;
    assign lrclk_o     = lrclk_q;
    assign sampstart_o = ss_q;
    assign audio_l_o   = aud_l_q;
    assign audio_r_o   = aud_r_q;
    assign uflow_o     = uflow_q;
    assign uflow_cnt_o = ucnt_q;

endmodule
